// File: rtl/framebuffer_row_reader_if.sv
// Panel geometry package plus the bundled memory read port and pixel stream
// used by framebuffer_row_reader (master = reader, slave = memory/consumer).
package params;
    parameter int BYTES_PER_PIXEL  = 2;
    parameter int PIXEL_WIDTH      = 64;
    parameter int PIXEL_HEIGHT     = 32;
    parameter int PIXEL_HALFHEIGHT = 16;
endpackage

interface framebuffer_row_reader_if #(
    parameter int ADDR_W = 10,
    parameter int COL_W  = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] pix_data;
    logic [COL_W-1:0]  pix_col;
    logic              pix_last;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        output mem_addr, mem_en, pix_data, pix_col, pix_last, pix_valid,
        input  mem_q, pix_ready
    );

    modport slave (
        input  mem_addr, mem_en, pix_data, pix_col, pix_last, pix_valid,
        output mem_q, pix_ready
    );
endinterface

// File: rtl/framebuffer_row_reader.sv
// Scans one framebuffer row through a 2-cycle-latency read port into a 4-entry
// credit-limited output FIFO. Define SCANOUT_COLUMN_REVERSE_EN to scan columns descending.
module framebuffer_row_reader #(
    parameter int BYTES_PER_PIXEL  = params::BYTES_PER_PIXEL,
    parameter int PIXEL_WIDTH      = params::PIXEL_WIDTH,
    parameter int PIXEL_HEIGHT     = params::PIXEL_HEIGHT,
    parameter int PIXEL_HALFHEIGHT = params::PIXEL_HALFHEIGHT,
    localparam int ADDR_W = $clog2(PIXEL_WIDTH*PIXEL_HALFHEIGHT),
    localparam int ROW_W  = $clog2(PIXEL_HALFHEIGHT),
    localparam int COL_W  = $clog2(PIXEL_WIDTH),
    localparam int DATA_W = 8*BYTES_PER_PIXEL*(PIXEL_HEIGHT/PIXEL_HALFHEIGHT)
) (
    input  logic                        clk_root,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [ROW_W-1:0]            row,
    output logic                        busy,
    output logic                        done,
    framebuffer_row_reader_if.master    bus
);

`ifdef SCANOUT_COLUMN_REVERSE_EN
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(PIXEL_WIDTH-1);
    localparam logic [COL_W-1:0] COL_LAST  = '0;
    localparam bit               COL_DESC  = 1'b1;
`else
    localparam logic [COL_W-1:0] COL_FIRST = '0;
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(PIXEL_WIDTH-1);
    localparam bit               COL_DESC  = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               vld_p0, vld_p1;
    logic [COL_W-1:0]   col_p0, col_p1;
    logic               last_p0, last_p1;
    logic [1:0]         wr_ptr_q, rd_ptr_q;
    logic [2:0]         fifo_cnt_q, fifo_cnt_d;
    logic [DATA_W-1:0]  fifo_data [4];
    logic [COL_W-1:0]   fifo_col  [4];
    logic               fifo_last [4];
    logic               issue, push, pop, credit;
    logic [ADDR_W-1:0]  rd_addr;

    // Reads already issued count against FIFO space so the FIFO can never overflow.
    assign credit     = (fifo_cnt_q + 3'(vld_p0) + 3'(vld_p1)) < 3'd4;
    assign issue      = (state_q == FETCH) && credit;
    assign push       = vld_p1;
    assign pop        = bus.pix_valid && bus.pix_ready;
    assign fifo_cnt_d = fifo_cnt_q + 3'(push) - 3'(pop);
    assign rd_addr    = ADDR_W'(row_q) * ADDR_W'(PIXEL_WIDTH) + ADDR_W'(col_q);

    assign bus.mem_en    = issue;
    assign bus.mem_addr  = issue ? rd_addr : '0;
    assign bus.pix_valid = (fifo_cnt_q != 3'd0);
    assign bus.pix_data  = bus.pix_valid ? fifo_data[rd_ptr_q] : '0;
    assign bus.pix_col   = bus.pix_valid ? fifo_col[rd_ptr_q]  : '0;
    assign bus.pix_last  = bus.pix_valid && fifo_last[rd_ptr_q];
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d   = row;
                    col_d   = COL_FIRST;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (issue) begin
                    if (col_q == COL_LAST) state_d = DRAIN;
                    else if (COL_DESC)     col_d   = col_q - COL_W'(1);
                    else                   col_d   = col_q + COL_W'(1);
                end
            end
            DRAIN: begin
                // Leave as soon as the last word is being popped this cycle.
                if (!vld_p0 && !vld_p1 && (fifo_cnt_d == 3'd0)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_root or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            vld_p0     <= issue;
            vld_p1     <= vld_p0;
            fifo_cnt_q <= fifo_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
        end
    end

    // p0: issue cycle tags; p1: tags aligned with mem_q arrival
    always_ff @(posedge clk_root) begin
        col_p0  <= col_q;
        last_p0 <= (col_q == COL_LAST);
        col_p1  <= col_p0;
        last_p1 <= last_p0;
        if (push) begin
            fifo_data[wr_ptr_q] <= bus.mem_q;
            fifo_col[wr_ptr_q]  <= col_p1;
            fifo_last[wr_ptr_q] <= last_p1;
        end
    end

endmodule

// File: tb/tb_framebuffer_row_reader.sv
// Scoreboard bench for framebuffer_row_reader with a 2-cycle memory returning mem_q = address.
module tb_framebuffer_row_reader;
    localparam int W = params::PIXEL_WIDTH;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] row;
    logic       busy;
    logic       done;
    logic [9:0] a1;

    framebuffer_row_reader_if #(.ADDR_W(10), .COL_W(6), .DATA_W(32)) bus ();

    framebuffer_row_reader dut (
        .clk_root(clk),
        .reset_n (reset_n),
        .start   (start),
        .row     (row),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, issued = 0, popped = 0, done_cnt = 0;
    int first_iss = 0, last_iss = 0, last_pop = 0, done_cyc = 0;
    int rdy_mode = 0;
    bit mon_en = 0;
    bit stall_prev = 0;
    logic [38:0] held;
    logic [9:0]  addr_q[$];
    logic [38:0] word_q[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    always @(posedge clk) begin
        a1        <= bus.mem_addr;
        bus.mem_q <= 32'(a1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
        end
    endtask

    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.pix_ready = 1'b1;
                1:       bus.pix_ready = 1'b0;
                default: bus.pix_ready = ($urandom_range(0, 99) < 30);
            endcase
        end
    end

    always @(negedge clk) begin
        logic [38:0] cur;
        cyc++;
        cur = {bus.pix_last, bus.pix_col, bus.pix_data};
        if (mon_en) begin
            if (bus.mem_en) begin
                if (addr_q.size() == 0) check("unexp_issue", 1, 0);
                else check("mem_addr", 64'(bus.mem_addr), 64'(addr_q.pop_front()));
                check("outstanding_le4", 64'((issued - popped + 1) <= 4), 1);
                issued++;
                if (issued == 1) first_iss = cyc;
                last_iss = cyc;
            end
            if (stall_prev) begin
                check("hold_valid", 64'(bus.pix_valid), 1);
                check("hold_stable", 64'(cur), 64'(held));
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (word_q.size() == 0) check("unexp_word", 1, 0);
                else check("pix_word", 64'(cur), 64'(word_q.pop_front()));
                popped++;
                last_pop = cyc;
            end
            stall_prev = bus.pix_valid && !bus.pix_ready;
            held = cur;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic int col_at(input int i);
`ifdef SCANOUT_COLUMN_REVERSE_EN
        return W - 1 - i;
`else
        return i;
`endif
    endfunction

    task automatic expect_row(input int r);
        int c;
        issued = 0; popped = 0; done_cnt = 0;
        for (int i = 0; i < W; i++) begin
            c = col_at(i);
            addr_q.push_back(10'(r*W + c));
            word_q.push_back({(i == W-1), 6'(c), 32'(r*W + c)});
        end
    endtask

    task automatic pulse_start(input int r);
        @(posedge clk); #1;
        start = 1'b1;
        row   = 4'(r);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_outputs_zero();
        check("rst_mem_en",    64'(bus.mem_en), 0);
        check("rst_mem_addr",  64'(bus.mem_addr), 0);
        check("rst_pix_valid", 64'(bus.pix_valid), 0);
        check("rst_pix_data",  64'(bus.pix_data), 0);
        check("rst_pix_col",   64'(bus.pix_col), 0);
        check("rst_pix_last",  64'(bus.pix_last), 0);
        check("rst_busy",      64'(busy), 0);
        check("rst_done",      64'(done), 0);
    endtask

    task automatic finish_row(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", 64'(done_cnt != 0), 1);
        check("done_after_pop", 64'(done_cyc - last_pop), 1);
        repeat (5) @(posedge clk);
        #1;
        check("done_count", 64'(done_cnt), 1);
        check("words_left", 64'(word_q.size()), 0);
        check("issued_total", 64'(issued), 64'(W));
        check("busy_idle", 64'(busy), 0);
    endtask

    task automatic run_row(input int r, input int mode, input bit lat, input bit dup);
        int n;
        rdy_mode = mode;
        expect_row(r);
        pulse_start(r);
        check("busy_after_start", 64'(busy), 1);
        if (lat) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!bus.pix_valid && n < 10);
            check("first_valid_lat", 64'(n), 3);
        end
        if (mode == 1) begin
            repeat (20) @(posedge clk);
            #1;
            check("stall_issued", 64'(issued), 4);
            check("stall_popped", 64'(popped), 0);
            rdy_mode = 0;
        end
        if (dup) begin
            repeat (10) @(posedge clk);
            pulse_start(r ^ 1);
        end
        finish_row(3000);
        if (mode == 0 && !dup) check("back_to_back", 64'(last_iss - first_iss), 64'(W - 1));
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        start   = 1'b0;
        row     = '0;
        #1;
        check_outputs_zero();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        run_row(3, 0, 1'b1, 1'b0);
        run_row(15, 1, 1'b0, 1'b0);
        run_row(7, 2, 1'b0, 1'b0);
        run_row(9, 0, 1'b0, 1'b1);

        // abandon a row partway, then confirm a clean restart
        rdy_mode = 0;
        expect_row(5);
        pulse_start(5);
        n = 0;
        while (issued < 20 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("reached_col20", 64'(issued >= 20), 1);
        #3;
        reset_n = 1'b0;
        #1;
        check_outputs_zero();
        mon_en = 1'b0;
        addr_q.delete();
        word_q.delete();
        stall_prev = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("stale_discarded", 64'(bus.pix_valid), 0);
        run_row(0, 0, 1'b0, 1'b0);

        run_row(1, 2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
